cpu_sequencer: RTL

//  Parametrised fetch/execute sequencer for the 8-bit CPU family: owns PC, IR and the one-hot micro-step

---
 rtl/cpu_pkg.sv | 15 +
 rtl/cpu_call_stack.sv | 60 ++++++
 rtl/cpu_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer slice.
// Holds the FSM state encoding and the step-vector constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IF  = 2'd0,
        ST_IE  = 2'd1,
        ST_HLT = 2'd2,
        ST_ERR = 2'd3
    } cpu_state_e;

    // Bit position of the first micro-step after a fetch completes.
    localparam int STEP_FIRST_BIT = 0;

endpackage

// File: rtl/cpu_call_stack.sv
// Hardware return-address LIFO for CALL/RET.
// The caller must check full/empty before asserting push/pop.
module cpu_call_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [SPW-1:0]   sp_r;
    logic [IDXW-1:0]  wr_idx_s;
    logic [IDXW-1:0]  rd_idx_s;
    logic             full_s;
    logic             empty_s;

    // Pointer decode: next free slot, current top slot, occupancy flags.
    always_comb begin
        wr_idx_s = IDXW'(sp_r);
        rd_idx_s = IDXW'(sp_r - SPW'(1));
        full_s   = (sp_r == SPW'(DEPTH));
        empty_s  = (sp_r == SPW'(0));
        if (empty_s) begin
            top = {WIDTH{1'b0}};
        end else begin
            top = mem_r[rd_idx_s];
        end
    end

    assign full  = full_s;
    assign empty = empty_s;

    // Stack storage and pointer; push wins if both are ever requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r <= SPW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !full_s) begin
            mem_r[wr_idx_s] <= push_data;
            sp_r            <= sp_r + SPW'(1);
        end else if (pop && !empty_s) begin
            sp_r <= sp_r - SPW'(1);
        end else begin
            sp_r <= sp_r;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns PC, IR, the one-hot micro-step vector and
// the return stack; fetches over a req/ready port and faults on stack misuse.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int INST_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int STEPS       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    input  logic                  inst_condition,
    input  logic                  end_inst,
    input  logic                  jmp_inst,
    input  logic                  call_inst,
    input  logic                  ret_inst,
    input  logic                  hlt_inst,
    input  logic                  resume,
    input  logic [ADDR_WIDTH-1:0] jmp_address,
    output logic [INST_WIDTH-1:0] ir,
    output logic [STEPS-1:0]      steps,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [1:0]            state,
    output logic                  stack_err
);

    localparam logic [STEPS-1:0] STEP_FIRST = STEPS'(1) << STEP_FIRST_BIT;

    cpu_state_e            state_r;
    cpu_state_e            state_nxt_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_nxt_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic [INST_WIDTH-1:0] ir_r;
    logic [INST_WIDTH-1:0] ir_nxt_s;
    logic [STEPS-1:0]      steps_r;
    logic [STEPS-1:0]      steps_nxt_s;
    logic                  stack_err_r;
    logic                  stack_err_nxt_s;
    logic                  mem_req_r;

    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] top_s;
    logic                  full_s;
    logic                  empty_s;

    cpu_call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_call_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign pc_inc_s = pc_r + ADDR_WIDTH'(1);

    // Next-state, step and PC decode; stack ops only on end/skip cycles.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        ir_nxt_s        = ir_r;
        steps_nxt_s     = steps_r;
        stack_err_nxt_s = stack_err_r;
        push_s          = 1'b0;
        pop_s           = 1'b0;
        case (state_r)
            ST_IF: begin
                if (mem_ready) begin
                    ir_nxt_s    = mem_rdata;
                    steps_nxt_s = STEP_FIRST;
                    state_nxt_s = ST_IE;
                end else begin
                    state_nxt_s = ST_IF;
                end
            end
            ST_IE: begin
                if (hlt_inst) begin
                    state_nxt_s = ST_HLT;
                    steps_nxt_s = {STEPS{1'b0}};
                end else if (end_inst || !inst_condition) begin
                    steps_nxt_s = {STEPS{1'b0}};
                    state_nxt_s = ST_IF;
                    if (ret_inst) begin
                        if (empty_s) begin
                            state_nxt_s     = ST_ERR;
                            stack_err_nxt_s = 1'b1;
                        end else begin
                            pc_nxt_s = top_s;
                            pop_s    = 1'b1;
                        end
                    end else if (call_inst) begin
                        if (full_s) begin
                            state_nxt_s     = ST_ERR;
                            stack_err_nxt_s = 1'b1;
                        end else begin
                            pc_nxt_s = jmp_address;
                            push_s   = 1'b1;
                        end
                    end else if (jmp_inst) begin
                        pc_nxt_s = jmp_address;
                    end else begin
                        pc_nxt_s = pc_inc_s;
                    end
                end else begin
                    // No implicit end: the top step wraps back to the first.
                    steps_nxt_s = {steps_r[STEPS-2:0], steps_r[STEPS-1]};
                end
            end
            ST_HLT: begin
                if (resume) begin
                    pc_nxt_s    = pc_inc_s;
                    state_nxt_s = ST_IF;
                end else begin
                    state_nxt_s = ST_HLT;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s     = ST_ERR;
                steps_nxt_s     = {STEPS{1'b0}};
                stack_err_nxt_s = 1'b1;
            end
        endcase
    end

    // Architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IF;
            pc_r        <= {ADDR_WIDTH{1'b0}};
            ir_r        <= {INST_WIDTH{1'b0}};
            steps_r     <= {STEPS{1'b0}};
            stack_err_r <= 1'b0;
            mem_req_r   <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            steps_r     <= steps_nxt_s;
            stack_err_r <= stack_err_nxt_s;
            mem_req_r   <= (state_nxt_s == ST_IF);
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = pc_r;
    assign ir        = ir_r;
    assign steps     = steps_r;
    assign pc        = pc_r;
    assign state     = state_r;
    assign stack_err = stack_err_r;

endmodule
